load_align_w: RTL and testbench
===============================

Name: load_align_w

Overview:
- Load-side counterpart to the M-stage store byte-enable/SwMode decode.
- Acts as the M→W pipeline register for load results. It captures the M-stage instruction, address low bits, raw data-memory word and old rt value.
- In W it produces the aligned, sign/zero-extended load value, including lwl/lwr merges, the register-write enable and a misaligned-load flag.
- Sits between the data memory read port and the W-stage register-file write mux.

Parameters:
- ADEL_EN, 1, when 1, misaligned lh/lhu/lw raise AdELW and suppress RegWriteLdW; when 0, AdELW is tied to 0 and the low address bits are ignored for lh/lw.
- BUBBLE_INSTR, 32'h0000_0000, instruction value loaded into InstrW on reset or flush.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- Stall  input  1  hold W register contents
- Flush  input  1  load bubble into W register
- InstrM  input  32  M-stage instruction
- AddrM  input  32  M-stage effective address; only [1:0] are used
- MemRDataM  input  32  word read from data memory at {AddrM[31:2],2'b00}
- RtOldM  input  32  forwarded rt value, used by lwl/lwr
- InstrW  output  32  registered instruction
- LoadDataW  output  32  aligned/extended load result
- RegWriteLdW  output  1  1 when InstrW is a load and must write rt
- AdELW  output  1  misaligned-load exception flag for InstrW

Behaviour:
- Register priority each cycle: reset > Flush > Stall > load.
  - reset or Flush: InstrW=BUBBLE_INSTR; addr/data/rt registers = 0.
  - Stall: all registers hold.
  - Otherwise: capture InstrM, AddrM[1:0], MemRDataM, RtOldM.
- Latency: exactly one cycle M→W. Outputs are combinational from the registers only, with no combinational path from any M input.
- Reset values: InstrW=0, LoadDataW=0, RegWriteLdW=0, AdELW=0.
- Decode on InstrW[31:26]: lb 6'h20, lh 6'h21, lwl 6'h22, lw 6'h23, lbu 6'h24, lhu 6'h25, lwr 6'h26. Any other opcode: LoadDataW=0, RegWriteLdW=0, AdELW=0.
- Little-endian byte extraction, with A = registered addr[1:0]:
  - lb/lbu: byte A (bits 8A+7:8A), sign- or zero-extended.
  - lh/lhu: half A[1] (A=0 → [15:0], A=2 → [31:16]), sign- or zero-extended.
  - lw: full word.
- lwl (M = mem, R = rt):
  - A=0: {M[7:0],R[23:0]}
  - A=1: {M[15:0],R[15:0]}
  - A=2: {M[23:0],R[7:0]}
  - A=3: M
- lwr:
  - A=0: M
  - A=1: {R[31:24],M[31:8]}
  - A=2: {R[31:16],M[31:16]}
  - A=3: {R[31:8],M[31:24]}
- Misalignment (ADEL_EN=1): lh/lhu with A[0]=1, or lw with A≠0, gives AdELW=1, RegWriteLdW=0 and LoadDataW=0. lb, lbu, lwl and lwr never fault.
- Stall together with Flush: Flush wins and a bubble is inserted.
- Reset asserted mid-stall: state clears on that edge.

Decomposition:
- Shared package `mem_pkg` holds:
  - opcode constants OP_LB..OP_LWR;
  - a load-kind enum (LD_NONE, LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WL, LD_WR);
  - the BUBBLE constant.
- Store-side decode uses the same package.
- One natural sub-module, `load_extend`: purely combinational, inputs kind, A, M, R; outputs data and misalign.
- `load_align_w` is the register plus this sub-module.

Test Plan:
- lb at A=3, MemRDataM=32'h80FF_1234 → next cycle LoadDataW=32'hFFFF_FF80, RegWriteLdW=1; lbu same inputs → 32'h0000_0080.
- lh at A=2, mem=32'h8001_7FFF → 32'hFFFF_8001; lh at A=1 → AdELW=1, RegWriteLdW=0, LoadDataW=0.
- lwl A=1 and lwr A=1, mem=32'hAABB_CCDD, rt=32'h1122_3344 → lwl gives 32'hCCDD_3344; lwr gives 32'h11AA_BBCC.
- Stall held 3 cycles while M inputs change → W outputs unchanged. Flush+Stall in the same cycle → InstrW=0, RegWriteLdW=0.
- reset asserted with valid lw in flight → next edge all outputs 0. Non-load opcode (addu) → RegWriteLdW=0, LoadDataW=0.
- Back-to-back loads lw A=0 then lbu A=2 on consecutive cycles → each result appears exactly one cycle after its M cycle, with no cross-contamination.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-access definitions: load opcodes, load kinds, the pipeline
// bubble and the registered M->W payload for the load path.
package mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPW    = 6;
  localparam int unsigned AW_LOW = 2;

  localparam logic [OPW-1:0] OP_LB  = 6'h20;
  localparam logic [OPW-1:0] OP_LH  = 6'h21;
  localparam logic [OPW-1:0] OP_LWL = 6'h22;
  localparam logic [OPW-1:0] OP_LW  = 6'h23;
  localparam logic [OPW-1:0] OP_LBU = 6'h24;
  localparam logic [OPW-1:0] OP_LHU = 6'h25;
  localparam logic [OPW-1:0] OP_LWR = 6'h26;

  localparam logic [XLEN-1:0] BUBBLE = 32'h0000_0000;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_B,
    LD_BU,
    LD_H,
    LD_HU,
    LD_W,
    LD_WL,
    LD_WR
  } ld_kind_e;

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [AW_LOW-1:0] addr;
    logic [XLEN-1:0]   rdata;
    logic [XLEN-1:0]   rtold;
  } ldw_reg_t;

  function automatic ld_kind_e decode_load(input logic [OPW-1:0] op);
    ld_kind_e kind;
    case (op)
      OP_LB:   kind = LD_B;
      OP_LBU:  kind = LD_BU;
      OP_LH:   kind = LD_H;
      OP_LHU:  kind = LD_HU;
      OP_LW:   kind = LD_W;
      OP_LWL:  kind = LD_WL;
      OP_LWR:  kind = LD_WR;
      default: kind = LD_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: picks the addressed byte/half/word out of the
// memory word, extends it, merges lwl/lwr with old rt and flags misalignment.
module load_extend
  import mem_pkg::*;
#(
  parameter bit ADEL_EN = 1'b1
) (
  input  ld_kind_e           kind_i,
  input  logic [AW_LOW-1:0]  a_i,
  input  logic [XLEN-1:0]    m_i,
  input  logic [XLEN-1:0]    r_i,
  output logic [XLEN-1:0]    data_o,
  output logic               misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [XLEN-1:0] merged;

  always_comb begin
    byte_sel = m_i[7:0];
    case (a_i)
      2'd0:    byte_sel = m_i[7:0];
      2'd1:    byte_sel = m_i[15:8];
      2'd2:    byte_sel = m_i[23:16];
      default: byte_sel = m_i[31:24];
    endcase
    half_sel = a_i[1] ? m_i[31:16] : m_i[15:0];
  end

  always_comb begin
    misalign_o = 1'b0;
    if (ADEL_EN) begin
      case (kind_i)
        LD_H, LD_HU: misalign_o = a_i[0];
        LD_W:        misalign_o = (a_i != 2'd0);
        default:     misalign_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    merged = '0;
    case (kind_i)
      LD_B:  merged = {{24{byte_sel[7]}}, byte_sel};
      LD_BU: merged = {24'h0, byte_sel};
      LD_H:  merged = {{16{half_sel[15]}}, half_sel};
      LD_HU: merged = {16'h0, half_sel};
      LD_W:  merged = m_i;
      // lwl fills the high end of rt from the low end of the memory word
      LD_WL: begin
        case (a_i)
          2'd0:    merged = {m_i[7:0],  r_i[23:0]};
          2'd1:    merged = {m_i[15:0], r_i[15:0]};
          2'd2:    merged = {m_i[23:0], r_i[7:0]};
          default: merged = m_i;
        endcase
      end
      LD_WR: begin
        case (a_i)
          2'd0:    merged = m_i;
          2'd1:    merged = {r_i[31:24], m_i[31:8]};
          2'd2:    merged = {r_i[31:16], m_i[31:16]};
          default: merged = {r_i[31:8],  m_i[31:24]};
        endcase
      end
      default: merged = '0;
    endcase
    data_o = misalign_o ? '0 : merged;
  end

endmodule

// File: rtl/load_align_w.sv
// M->W pipeline register for load results; W-side outputs are decoded purely
// from the registered payload so no M input reaches them combinationally.
module load_align_w
  import mem_pkg::*;
#(
  parameter bit          ADEL_EN      = 1'b1,
  parameter logic [31:0] BUBBLE_INSTR = BUBBLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] InstrM,
  input  logic [31:0] AddrM,
  input  logic [31:0] MemRDataM,
  input  logic [31:0] RtOldM,
  output logic [31:0] InstrW,
  output logic [31:0] LoadDataW,
  output logic        RegWriteLdW,
  output logic        AdELW
);

  ldw_reg_t reg_q, reg_d;
  ld_kind_e kind;
  logic     misalign;
  logic     unused_addr_hi;

  // Only the byte offset matters; the word address was consumed by the memory.
  assign unused_addr_hi = ^AddrM[31:2];

  // Priority below reset: flush, then stall, then capture.
  always_comb begin
    reg_d = reg_q;
    if (Flush) begin
      reg_d       = '0;
      reg_d.instr = BUBBLE_INSTR;
    end else if (!Stall) begin
      reg_d.instr = InstrM;
      reg_d.addr  = AddrM[1:0];
      reg_d.rdata = MemRDataM;
      reg_d.rtold = RtOldM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q       <= '0;
      reg_q.instr <= BUBBLE_INSTR;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign kind = decode_load(reg_q.instr[31:26]);

  load_extend #(
    .ADEL_EN (ADEL_EN)
  ) u_extend (
    .kind_i     (kind),
    .a_i        (reg_q.addr),
    .m_i        (reg_q.rdata),
    .r_i        (reg_q.rtold),
    .data_o     (LoadDataW),
    .misalign_o (misalign)
  );

  assign InstrW      = reg_q.instr;
  assign AdELW       = misalign;
  assign RegWriteLdW = (kind != LD_NONE) && !misalign;

endmodule

// File: tb/tb_load_align_w.sv
// Randomised bench for load_align_w: a byte-level reference model predicts the
// W outputs every cycle, plus directed literal checks for the key cases.
module tb_load_align_w;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush;
  logic [31:0] InstrM, AddrM, MemRDataM, RtOldM;
  logic [31:0] InstrW, LoadDataW;
  logic        RegWriteLdW, AdELW;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // model of the W register contents
  logic [31:0] m_instr, m_mem, m_rt;
  logic [1:0]  m_a;

  always #5 clk = ~clk;

  load_align_w dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (Stall),
    .Flush       (Flush),
    .InstrM      (InstrM),
    .AddrM       (AddrM),
    .MemRDataM   (MemRDataM),
    .RtOldM      (RtOldM),
    .InstrW      (InstrW),
    .LoadDataW   (LoadDataW),
    .RegWriteLdW (RegWriteLdW),
    .AdELW       (AdELW)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return 8'((w >> (8 * i)) & 32'hFF);
  endfunction

  // reference: build the result byte by byte from memory and rt bytes
  function automatic void model_out(input logic [31:0] instr, input logic [1:0] a,
                                    input logic [31:0] mem, input logic [31:0] rt,
                                    output logic [31:0] d, output logic we,
                                    output logic adel);
    int op = int'(instr[31:26]);
    int ai = int'(a);
    logic [31:0] v;
    d = 0; we = 0; adel = 0;
    case (op)
      'h20, 'h24: begin
        v = 32'(byte_of(mem, ai));
        if (op == 'h20 && v >= 32'h80) v = v - 32'h100;
        d = v; we = 1;
      end
      'h21, 'h25: begin
        if (ai % 2 != 0) adel = 1;
        else begin
          v = (mem >> (16 * (ai / 2))) & 32'hFFFF;
          if (op == 'h21 && v >= 32'h8000) v = v - 32'h10000;
          d = v; we = 1;
        end
      end
      'h23: begin
        if (ai != 0) adel = 1;
        else begin d = mem; we = 1; end
      end
      'h22: begin
        for (int i = 0; i < 4; i++)
          d = d | (32'(i >= 3 - ai ? byte_of(mem, i - (3 - ai)) : byte_of(rt, i)) << (8 * i));
        we = 1;
      end
      'h26: begin
        for (int i = 0; i < 4; i++)
          d = d | (32'(i <= 3 - ai ? byte_of(mem, i + ai) : byte_of(rt, i)) << (8 * i));
        we = 1;
      end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] ed;
    logic        ew, ea;
    if (checking) begin
      model_out(m_instr, m_a, m_mem, m_rt, ed, ew, ea);
      chk("model InstrW", InstrW, m_instr);
      chk("model LoadDataW", LoadDataW, ed);
      chk("model RegWriteLdW", 32'(RegWriteLdW), 32'(ew));
      chk("model AdELW", 32'(AdELW), 32'(ea));
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic fl, input logic [31:0] ins,
                     input logic [31:0] ad, input logic [31:0] mem, input logic [31:0] rt);
    reset = rst; Stall = st; Flush = fl;
    InstrM = ins; AddrM = ad; MemRDataM = mem; RtOldM = rt;
    @(posedge clk);
    if (rst || fl) begin
      m_instr = 0; m_a = 0; m_mem = 0; m_rt = 0;
    end else if (!st) begin
      m_instr = ins; m_a = ad[1:0]; m_mem = mem; m_rt = rt;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0123456};
  endfunction

  initial begin
    logic [5:0] op_tbl [11];
    logic [31:0] lw_i;
    op_tbl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00, 6'h2B, 6'h0F, 6'h27};
    m_instr = 0; m_a = 0; m_mem = 0; m_rt = 0;

    cyc(1, 0, 0, mk(6'h23), 32'h0, 32'hFFFF_FFFF, 32'h1);
    cyc(1, 1, 0, mk(6'h23), 32'h0, 32'hFFFF_FFFF, 32'h1);
    checking = 1'b1;
    chk("reset InstrW", InstrW, 32'h0);
    chk("reset LoadDataW", LoadDataW, 32'h0);
    chk("reset RegWriteLdW", 32'(RegWriteLdW), 32'h0);
    chk("reset AdELW", 32'(AdELW), 32'h0);

    cyc(0, 0, 0, mk(6'h20), 32'h3, 32'h80FF_1234, 32'h0);
    chk("lb A3", LoadDataW, 32'hFFFF_FF80);
    chk("lb A3 we", 32'(RegWriteLdW), 32'h1);
    cyc(0, 0, 0, mk(6'h24), 32'h3, 32'h80FF_1234, 32'h0);
    chk("lbu A3", LoadDataW, 32'h0000_0080);
    cyc(0, 0, 0, mk(6'h21), 32'h2, 32'h8001_7FFF, 32'h0);
    chk("lh A2", LoadDataW, 32'hFFFF_8001);
    cyc(0, 0, 0, mk(6'h21), 32'h1, 32'h8001_7FFF, 32'h0);
    chk("lh A1 adel", 32'(AdELW), 32'h1);
    chk("lh A1 we", 32'(RegWriteLdW), 32'h0);
    chk("lh A1 data", LoadDataW, 32'h0);
    cyc(0, 0, 0, mk(6'h22), 32'h1, 32'hAABB_CCDD, 32'h1122_3344);
    chk("lwl A1", LoadDataW, 32'hCCDD_3344);
    cyc(0, 0, 0, mk(6'h26), 32'h1, 32'hAABB_CCDD, 32'h1122_3344);
    chk("lwr A1", LoadDataW, 32'h11AA_BBCC);

    lw_i = mk(6'h23);
    cyc(0, 0, 0, lw_i, 32'h100, 32'h1234_5678, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, {6'h20, 26'($urandom)}, $urandom, $urandom, $urandom);
      chk("stall InstrW", InstrW, lw_i);
      chk("stall LoadDataW", LoadDataW, 32'h1234_5678);
    end
    cyc(0, 1, 1, mk(6'h23), 32'h0, 32'h5555_5555, 32'h0);
    chk("flush+stall InstrW", InstrW, 32'h0);
    chk("flush+stall we", 32'(RegWriteLdW), 32'h0);

    cyc(0, 0, 0, lw_i, 32'h0, 32'hCAFE_F00D, 32'h0);
    cyc(1, 1, 0, lw_i, 32'h0, 32'hCAFE_F00D, 32'h0);
    chk("reset mid InstrW", InstrW, 32'h0);
    chk("reset mid LoadDataW", LoadDataW, 32'h0);
    chk("reset mid we", 32'(RegWriteLdW), 32'h0);

    cyc(0, 0, 0, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h0, 32'hFFFF_FFFF, 32'h0);
    chk("addu we", 32'(RegWriteLdW), 32'h0);
    chk("addu data", LoadDataW, 32'h0);

    cyc(0, 0, 0, mk(6'h23), 32'h0, 32'hDEAD_BEEF, 32'h0);
    chk("b2b lw", LoadDataW, 32'hDEAD_BEEF);
    cyc(0, 0, 0, mk(6'h24), 32'h2, 32'h1122_3344, 32'h0);
    chk("b2b lbu", LoadDataW, 32'h0000_0022);

    for (int n = 0; n < 2000; n++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0),
          {op_tbl[$urandom_range(0, 10)], 26'($urandom)},
          $urandom, $urandom, $urandom);
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
